// File: rtl/dcp_serializer.sv
// dcp_serializer: wide-to-narrow Decoupled down-converter, emits lanes LSB-first.
// Define DCP_SER_FRMCNT_EN to build the saturating emitted-frame counter on oFrmCnt.
module dcp_serializer #(
    parameter int IN_W = 32,
    parameter int OUT_W = 8,
    localparam int RATIO = IN_W / OUT_W,
    localparam int LW = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iDcpIn_Vld,
    output logic              iDcpIn_Rdy,
    input  logic [IN_W+LW:0]  iDcpIn_Pld,
    output logic              oDcpOut_Vld,
    input  logic              oDcpOut_Rdy,
    output logic [OUT_W:0]    oDcpOut_Pld,
    input  logic              iFlush,
    output logic              oBusy,
    output logic [15:0]       oFrmCnt
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t            r_state;
    logic [LW-1:0]     r_cnt;
    logic [LW-1:0]     r_lim;
    logic [IN_W-1:0]   r_held;
    logic              r_last;
    logic              w_in_last;
    logic [LW-1:0]     w_lanes;
    logic [LW-1:0]     w_lim;
    logic              w_fin;
    logic              w_hs;
    logic              w_acc;
    assign w_in_last = iDcpIn_Pld[IN_W+LW];
    assign w_lanes = iDcpIn_Pld[IN_W +: LW];
    // Only a last word may end early; out-of-range lane counts clamp to a full word.
    assign w_lim = !w_in_last ? LW'(RATIO - 1) :
                   (32'(w_lanes) >= RATIO) ? LW'(RATIO - 1) : w_lanes;
    assign w_fin = r_cnt == r_lim;
    assign w_hs = oDcpOut_Vld && oDcpOut_Rdy;
    assign iDcpIn_Rdy = !iRst && !iFlush && (r_state == IDLE || (oDcpOut_Rdy && w_fin));
    assign w_acc = iDcpIn_Vld && iDcpIn_Rdy;
    assign oDcpOut_Vld = r_state == SHIFT;
    assign oBusy = r_state == SHIFT;
    assign oDcpOut_Pld = {r_last && w_fin, r_held[32'(r_cnt) * OUT_W +: OUT_W]};
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= IDLE;
            r_cnt <= '0;
            r_lim <= '0;
            r_held <= '0;
            r_last <= 1'b0;
        end else if (iFlush) begin
            r_state <= IDLE;
            r_cnt <= '0;
        end else if (w_acc) begin
            r_state <= SHIFT;
            r_cnt <= '0;
            r_lim <= w_lim;
            r_held <= iDcpIn_Pld[IN_W-1:0];
            r_last <= w_in_last;
        end else if (w_hs) begin
            if (w_fin) begin
                r_state <= IDLE;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`ifdef DCP_SER_FRMCNT_EN
    logic [15:0] r_frm;
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)
            r_frm <= '0;
        else if (w_hs && oDcpOut_Pld[OUT_W] && r_frm != 16'hFFFF)
            r_frm <= r_frm + 16'd1;
    end
    assign oFrmCnt = r_frm;
`else
    assign oFrmCnt = 16'h0;
`endif
endmodule

// File: tb/tb_dcp_serializer.sv
// tb_dcp_serializer: scoreboard bench; a lane-list model feeds a queue that the output monitor drains.
module tb_dcp_serializer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_vld = 1'b0;
    logic        in_rdy;
    logic [34:0] i_pld = '0;
    logic        o_vld;
    logic        o_rdy = 1'b1;
    logic [8:0]  o_pld;
    logic        flush = 1'b0;
    logic        busy;
    logic [15:0] frm;
    int          checks = 0;
    int          failures = 0;
    int          frm_exp = 0;
    logic [8:0]  q[$];
    bit          rnd_rdy = 1'b0;
    logic        stall_p = 1'b0;
    logic        flush_p = 1'b0;
    logic [8:0]  pld_p = '0;
`ifdef DCP_SER_FRMCNT_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    always #5 clk = ~clk;

    dcp_serializer dut (
        .iClk(clk), .iRst(rst),
        .iDcpIn_Vld(i_vld), .iDcpIn_Rdy(in_rdy), .iDcpIn_Pld(i_pld),
        .oDcpOut_Vld(o_vld), .oDcpOut_Rdy(o_rdy), .oDcpOut_Pld(o_pld),
        .iFlush(flush), .oBusy(busy), .oFrmCnt(frm)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected beats: lanes 0..lim of the word, last flagged on the final kept lane only.
    function automatic void push_word(input logic [31:0] d, input logic l, input logic [1:0] n);
        int lim;
        lim = l ? int'(n) : 3;
        for (int i = 0; i <= lim; i++)
            q.push_back({l && (i == lim), d[8*i +: 8]});
    endfunction

    always @(negedge clk)
        if (!rst && i_vld && in_rdy)
            push_word(i_pld[31:0], i_pld[34], i_pld[33:32]);

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stall_p = 1'b0;
            flush_p = 1'b0;
            frm_exp = 0;
        end else begin
            if (stall_p && !flush_p) begin
                chk("hold_vld", o_vld, 1);
                chk("hold_pld", o_pld, pld_p);
            end
            chk("frmcnt", frm, FC ? frm_exp : 0);
            if (o_vld && o_rdy) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=none", o_pld);
                end else begin
                    chk("beat", o_pld, q.pop_front());
                end
                if (o_pld[8] && frm_exp < 65535) frm_exp++;
            end
            if (flush) q.delete();
            stall_p = o_vld && !o_rdy;
            flush_p = flush;
            pld_p = o_pld;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rnd_rdy) o_rdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [31:0] d, input logic l, input logic [1:0] n);
        bit ok;
        ok = 1'b0;
        i_vld = 1'b1;
        i_pld = {l, n, d};
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_rdy) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
        chk("send_accept", ok, 1);
        cyc();
        i_vld = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat[7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        @(posedge clk);
        #1;
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_vld", o_vld, 0);
        chk("rst_pld", o_pld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frm", frm, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("idle_rdy", in_rdy, 1);

        send(32'hDDCCBBAA, 1'b0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_vld", o_vld, 1);
            chk("t1_in_rdy", in_rdy, k == 3);
            cyc();
        end
        chk("t1_idle", busy, 0);

        fork
            begin
                send(32'h04030201, 1'b0, 2'd0);
                send(32'h08070605, 1'b1, 2'd3);
            end
            begin
                int first, lastk, n;
                first = -1;
                lastk = -1;
                n = 0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (o_vld) begin
                        if (first < 0) first = k;
                        lastk = k;
                        n++;
                    end
                end
                chk("t2_beats", n, 8);
                chk("t2_span", lastk - first + 1, 8);
            end
        join
        chk("t2_frm", frm, FC ? 1 : 0);

        send(32'h44332211, 1'b1, 2'd1);
        repeat (3) cyc();
        chk("t3_idle", busy, 0);
        chk("t3_q", q.size(), 0);

        send(32'hA4A3A2A1, 1'b0, 2'd0);
        for (int k = 0; k < 7; k++) begin
            o_rdy = pat[k];
            cyc();
        end
        o_rdy = 1'b1;
        chk("t4_idle", busy, 0);
        chk("t4_q", q.size(), 0);

        send(32'h5D5C5B5A, 1'b0, 2'd0);
        cyc();
        cyc();
        o_rdy = 1'b0;
        flush = 1'b1;
        i_vld = 1'b1;
        i_pld = {1'b1, 2'd3, 32'h69686766};
        @(negedge clk);
        chk("t5_no_acc", in_rdy, 0);
        chk("t5_busy_pre", busy, 1);
        cyc();
        flush = 1'b0;
        chk("t5_vld", o_vld, 0);
        chk("t5_busy", busy, 0);
        @(negedge clk);
        chk("t5_acc_rdy", in_rdy, 1);
        cyc();
        i_vld = 1'b0;
        chk("t5_loaded", o_vld, 1);
        chk("t5_lane0", o_pld, 9'h066);
        o_rdy = 1'b1;
        repeat (5) cyc();
        chk("t5_q", q.size(), 0);

        send(32'h7F7E7D7C, 1'b1, 2'd3);
        cyc();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_vld", o_vld, 0);
        chk("t6_frm", frm, 0);
        chk("t6_busy", busy, 0);
        chk("t6_in_rdy", in_rdy, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        cyc();
        send(32'h13121110, 1'b0, 2'd0);
        chk("t6_lane0", o_pld, 9'h010);
        repeat (5) cyc();
        chk("t6_q", q.size(), 0);

        rnd_rdy = 1'b1;
        for (int w = 0; w < 300; w++) begin
            if ($urandom_range(0, 15) == 0) begin
                flush = 1'b1;
                cyc();
                flush = 1'b0;
            end
            send($urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) cyc();
        end
        rnd_rdy = 1'b0;
        o_rdy = 1'b1;
        for (int k = 0; k < 100 && (o_vld || q.size() != 0); k++) cyc();
        chk("drain_q", q.size(), 0);
        chk("drain_vld", o_vld, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcp_serializer.md
Name: dcp_serializer

Overview:
- Transmit-side Decoupled width down-converter. Accepts wide words plus frame sideband from an upstream buffer and emits narrow lanes LSB-first toward a byte-wide egress link.
- Full throughput: one narrow beat per cycle, with no bubble between consecutive input words.
- Sits between the egress DcpFifo output and the port transmit logic.

Parameters:
- IN_W, 32, input data width; must be an integer multiple of OUT_W.
- OUT_W, 8, output lane width.
- RATIO, IN_W/OUT_W, lanes per word; derived, never overridden.
- LW, (RATIO>1)?$clog2(RATIO):1, lane-index width; derived, never overridden.

Ports:
- iClk, input, 1, clock.
- iRst, input, 1, asynchronous active-high reset.
- iDcpIn, Decoupled.slave, DW=IN_W+1+LW. Pld = {last, lanesM1[LW-1:0], data[IN_W-1:0]}.
- oDcpOut, Decoupled.master, DW=OUT_W+1. Pld = {last, data[OUT_W-1:0]}.
- iFlush, input, 1, synchronous discard of the held word.
- oBusy, input-side status output, 1: high while a word is held.
- oFrmCnt, output, 16: count of emitted frames (see Optional Feature).

Behaviour:
- Reset values, asynchronous on iRst: state=IDLE, lane counter=0, held word=0, oDcpOut.Vld=0, oDcpOut.Pld=0, iDcpIn.Rdy=0 while iRst is high, oBusy=0, oFrmCnt=0.
- States:
  - IDLE: no word held.
  - SHIFT: word held, lane counter cnt in 0..lim.
- lim:
  - Non-last word: lim = RATIO-1, and lanesM1 is ignored.
  - Last word: lim = lanesM1. Lanes above lim are dropped.
  - A lanesM1 value >= RATIO is clamped to RATIO-1.
- Output is a direct register view: Vld = (state==SHIFT); data = held[cnt*OUT_W +: OUT_W]; last = held_last && (cnt==lim).
- Lane advance: when Vld && Rdy and cnt<lim, cnt increments.
- iDcpIn.Rdy = (state==IDLE) || (oDcpOut.Rdy && cnt==lim). This is combinational from oDcpOut.Rdy.
- Input accept (iDcpIn.Vld && iDcpIn.Rdy):
  - Latch data, last and lim; set cnt=0; state becomes SHIFT.
  - On the final-lane handshake this gives back-to-back words with no idle cycle.
- Final-lane handshake with no new input: state becomes IDLE.
- Latency: the first lane of an accepted word is valid the cycle after acceptance.
- Output stability: Vld and Pld hold steady while Vld && !Rdy. Never retract Vld without a handshake, except on flush or reset.
- iFlush:
  - Next edge: state=IDLE, cnt=0, Vld=0.
  - iDcpIn.Rdy is forced 0 during a flush cycle, so no accept happens that cycle.
  - Flush wins over every simultaneous event.
- oBusy = (state==SHIFT).
- Reset mid-word: the word is discarded and nothing is replayed.
- RATIO==1: degenerates to a single-register pipeline stage. lanesM1 is ignored and every word is one beat.

Optional Feature:
- Macro: DCP_SER_FRMCNT_EN.
- Defined: oFrmCnt increments on each output handshake whose last=1. It saturates at 16'hFFFF. It is cleared by iRst and is not cleared by iFlush.
- Undefined: no counter logic is built, and oFrmCnt is tied to 16'h0.

Test Plan:
- Single non-last word 32'hDDCCBBAA with oDcpOut.Rdy held 1:
  - Output beats AA, BB, CC, DD on consecutive cycles, all with last=0.
  - iDcpIn.Rdy is high in the DD cycle.
- Two back-to-back words 32'h04030201 then 32'h08070605 (last=1, lanesM1=3):
  - Eight contiguous beats 01..08 with no gap.
  - last=1 only on beat 08.
  - With DCP_SER_FRMCNT_EN defined, oFrmCnt=1.
- Last word 32'h44332211 with lanesM1=1:
  - Beats 11, then 22 with last=1.
  - Lanes 33 and 44 never appear; state returns to IDLE.
- Backpressure: oDcpOut.Rdy toggles 1,0,0,1,1,0,1 during a word:
  - Pld is stable through the stall cycles.
  - All four lanes are delivered in order and none is duplicated.
- Flush asserted at cnt=2 with iDcpIn.Vld=1 in the same cycle:
  - Next cycle: Vld=0 and oBusy=0.
  - The pending input is not accepted in the flush cycle and is accepted on the following cycle.
- iRst pulsed mid-word:
  - Vld drops asynchronously and oFrmCnt=0.
  - After release, a new word serializes from lane 0.
